write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 149 ++++++++++++++
 tb/tb_write_buffer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// write_buffer: posted-write FIFO between a cache controller and an SRAM
// controller. Buffered writes drain to SRAM in order; reads go straight through
// once the FIFO holds nothing they could depend on.
// Optional feature: define WB_ADDR_CHECK_EN to let a read bypass buffered
// writes whose address[31:3] does not match the read address.
module write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              address,
  input  logic [31:0]              wdata,
  input  logic                     write,
  input  logic                     read,
  output logic                     ready,
  output logic [63:0]              rdata,
  output logic [31:0]              sram_address,
  output logic [31:0]              sram_wdata,
  output logic                     sram_write,
  output logic                     sram_read,
  input  logic [63:0]              sram_rdata,
  input  logic                     sram_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_RD
  } state_t;

  logic [31:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  state_t        r_state;
  state_t        w_next;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_rd_done;
  logic w_rd_ok;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Acceptance looks only at the registered occupancy, so a full buffer
  // refuses a write even in the cycle it pops. rst gates ready low in reset.
  assign w_push    = write & ~w_full & rst;
  assign w_pop     = (r_state == S_DRAIN) & sram_ready;
  assign w_rd_done = (r_state == S_RD) & sram_ready;

`ifdef WB_ADDR_CHECK_EN
  logic w_match;

  // Compare the read address against every occupied entry, walking from head.
  always_comb begin
    w_match = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[idx][31:3] == address[31:3]))
        w_match = 1'b1;
    end
  end

  // A concurrent write wins the cycle, so the read only launches without one.
  assign w_rd_ok = read & ~write & (w_empty | ~w_match);
`else
  assign w_rd_ok = read & ~write & w_empty;
`endif

  // FIFO storage; entries need no reset since occupancy qualifies them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= address;
      r_data[r_tail] <= wdata;
    end
  end

  // Pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state and SRAM-side outputs; sram_ready is only looked at in DRAIN/RD.
  always_comb begin
    w_next       = r_state;
    sram_write   = 1'b0;
    sram_read    = 1'b0;
    sram_address = '0;
    sram_wdata   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_rd_ok)       w_next = S_RD;
        else if (!w_empty) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        sram_write   = 1'b1;
        sram_address = r_addr[r_head];
        sram_wdata   = r_data[r_head];
        if (sram_ready) w_next = S_IDLE;
      end
      S_RD: begin
        sram_read    = 1'b1;
        sram_address = address;
        if (sram_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Upstream handshake and read return.
  always_comb begin
    ready = w_push | w_rd_done;
    rdata = w_rd_done ? sram_rdata : '0;
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer (DEPTH=4). Buffered writes are pushed to a
// scoreboard queue on acceptance and popped when they appear on the SRAM side.
module tb_write_buffer;

  logic        clk;
  logic        rst;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        write;
  logic        read;
  logic        ready;
  logic [63:0] rdata;
  logic [31:0] sram_address;
  logic [31:0] sram_wdata;
  logic        sram_write;
  logic        sram_read;
  logic [63:0] sram_rdata;
  logic        sram_ready;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [63:0] rdq[$];
  int          total = 0;
  int          bad   = 0;

  write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .address(address), .wdata(wdata), .write(write),
    .read(read), .ready(ready), .rdata(rdata), .sram_address(sram_address),
    .sram_wdata(sram_wdata), .sram_write(sram_write), .sram_read(sram_read),
    .sram_rdata(sram_rdata), .sram_ready(sram_ready), .count(count),
    .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold a write until accepted (bounded), recording the accepted entry.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    ent_t e;
    write = 1'b1; address = a; wdata = d;
    #1;
    for (int n = 0; n < 50 && ready !== 1'b1; n++) begin
      tick();
      #1;
    end
    check("wr_ready", ready, 1);
    if (ready === 1'b1) begin
      e.a = a; e.d = d;
      q.push_back(e);
    end
    tick();
    write = 1'b0;
    #1;
  endtask

  // Wait (bounded) until the DUT presents an SRAM strobe.
  task automatic wait_strobe();
    for (int n = 0; n < 50 && !(sram_write === 1'b1 || sram_read === 1'b1); n++) begin
      tick();
      #1;
    end
    check("strobe_timeout", sram_write | sram_read, 1);
  endtask

  // Compare the presented write with the scoreboard head and complete it.
  task automatic drain_one();
    ent_t e;
    wait_strobe();
    check("drain_is_write", sram_write, 1);
    check("drain_no_read", sram_read, 0);
    check("sb_has_entry", 64'(q.size() != 0), 1);
    if (sram_write === 1'b1 && q.size() != 0) begin
      e = q.pop_front();
      check("drain_addr", sram_address, e.a);
      check("drain_data", sram_wdata, e.d);
    end
    sram_ready = 1'b1;
    tick();
    sram_ready = 1'b0;
    #1;
  endtask

  // Complete an RD cycle that is currently being presented.
  task automatic finish_read(input logic [31:0] a);
    logic [63:0] rd;
    check("rd_strobe", sram_read, 1);
    check("rd_addr", sram_address, a);
    rd = {$urandom, $urandom};
    sram_rdata = rd;
    rdq.push_back(rd);
    #1;
    check("rd_wait_ready", ready, 0);
    check("rd_wait_rdata", rdata, 0);
    sram_ready = 1'b1;
    #1;
    check("rd_ready", ready, 1);
    check("rd_data", rdata, rdq.pop_front());
    tick();
    read = 1'b0; sram_ready = 1'b0;
    #1;
    check("rd_rdata_idle", rdata, 0);
  endtask

  initial begin
    ent_t        e;
    int          drained;
    int          n;
    rst = 1'b0; address = '0; wdata = '0; write = 1'b0; read = 1'b0;
    sram_rdata = '0; sram_ready = 1'b0;

    // Reset state, with a write request held to show ready stays low.
    tick();
    write = 1'b1; address = 32'h40; wdata = 32'h1;
    #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", ready, 0);
    check("rst_swrite", sram_write, 0);
    check("rst_sread", sram_read, 0);
    write = 1'b0;
    tick();
    rst = 1'b1;

    // Single write then drain.
    tick();
    do_write(32'h400, 32'hAAAA_0001);
    check("w1_count", count, 1);
    drain_one();
    check("w1_count0", count, 0);
    check("w1_empty", empty, 1);
    tick();
    check("idle_addr", sram_address, 0);
    check("idle_swrite", sram_write, 0);
    check("idle_rdata", rdata, 0);

    // Fill with SRAM stalled; fifth write held until first pop.
    for (int i = 0; i < 4; i++) do_write(32'h1000 + 32'(i * 4), 32'hF0 + 32'(i));
    check("full_flag", full, 1);
    check("full_count", count, 4);
    write = 1'b1; address = 32'h1010; wdata = 32'hF4;
    #1;
    check("full_hold", ready, 0);
    wait_strobe();
    e = q.pop_front();
    check("full_pop_addr", sram_address, e.a);
    sram_ready = 1'b1;
    #1;
    check("full_pop_ready", ready, 0);
    tick();
    sram_ready = 1'b0;
    #1;
    check("full_after_pop_cnt", count, 3);
    check("fifth_ready", ready, 1);
    e.a = 32'h1010; e.d = 32'hF4;
    q.push_back(e);
    tick();
    write = 1'b0;
    #1;
    check("fifth_count", count, 4);
    for (int i = 0; i < 4; i++) drain_one();
    check("full_empty", empty, 1);

    // Wrap: two buffered, then eight simultaneous push/pop, then drain.
    do_write(32'h2000, 32'h5000);
    do_write(32'h2004, 32'h5001);
    for (int i = 0; i < 8; i++) begin
      wait_strobe();
      check("wrap_sb", 64'(q.size() != 0), 1);
      e = q.pop_front();
      check("wrap_addr", sram_address, e.a);
      check("wrap_data", sram_wdata, e.d);
      write = 1'b1; address = 32'h2008 + 32'(i * 4); wdata = 32'h5002 + 32'(i);
      sram_ready = 1'b1;
      #1;
      check("wrap_push_ready", ready, 1);
      e.a = address; e.d = wdata;
      q.push_back(e);
      tick();
      write = 1'b0; sram_ready = 1'b0;
      #1;
      check("wrap_count", count, 2);
    end
    drain_one();
    drain_one();
    check("wrap_empty", empty, 1);

    // Reset in the middle of a drain with three entries buffered.
    for (int i = 0; i < 3; i++) do_write(32'h3000 + 32'(i * 4), 32'h77 + 32'(i));
    wait_strobe();
    check("mid_swrite", sram_write, 1);
    check("mid_count", count, 3);
    rst = 1'b0;
    #1;
    check("mid_rst_swrite", sram_write, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    q.delete();
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_swrite", sram_write, 0);
    check("post_rst_empty", empty, 1);

`ifndef WB_ADDR_CHECK_EN
    // Read with buffered writes: both writes reach SRAM before the read.
    do_write(32'h600, 32'hB0);
    do_write(32'h604, 32'hB1);
    read = 1'b1; address = 32'h800; wdata = '0;
    #1;
    drained = 0;
    n = 0;
    while (n < 100 && sram_read !== 1'b1) begin
      if (sram_write === 1'b1 && q.size() != 0) begin
        check("rd_no_read_in_drain", sram_read, 0);
        e = q.pop_front();
        check("rd_drain_addr", sram_address, e.a);
        drained++;
        sram_ready = 1'b1;
        tick();
        sram_ready = 1'b0;
        #1;
      end else begin
        tick();
        #1;
      end
      n++;
    end
    check("rd_drained_first", drained, 2);
    finish_read(32'h800);
`else
    // Non-matching read bypasses the buffer; matching read drains first.
    do_write(32'h400, 32'hC0);
    read = 1'b1; address = 32'h800;
    #1;
    wait_strobe();
    check("ac_rd_first", sram_read, 1);
    check("ac_no_write", sram_write, 0);
    check("ac_count", count, 1);
    finish_read(32'h800);
    read = 1'b1; address = 32'h404;
    #1;
    wait_strobe();
    check("ac_match_drain", sram_write, 1);
    drain_one();
    wait_strobe();
    finish_read(32'h404);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
